nbit_miso_spi_buffer: RTL

NBIT_MISO_SPI_BUFFER -- requirements
Module: nbit_miso_spi_buffer

---
 rtl/nbit_miso_spi_buffer_if.sv | 32 +++
 rtl/nbit_miso_spi_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/nbit_miso_spi_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : nbit_miso_spi_buffer_if
// Brief    : Control/data bundle for the multi-byte MISO capture buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface nbit_miso_spi_buffer_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8
);
    logic                 i_START;
    logic [4:0]           i_N_receive;
    logic                 i_ABORT;
    logic                 i_MISO;
    logic [WIDTH*N-1:0]   o_DATA;
    logic [WIDTH-1:0]     o_BYTE;
    logic                 o_BYTE_VALID;
    logic                 o_DONE;
    logic                 o_BUSY;
    logic [4:0]           o_COUNT;

    modport master (
        output i_START, i_N_receive, i_ABORT, i_MISO,
        input  o_DATA, o_BYTE, o_BYTE_VALID, o_DONE, o_BUSY, o_COUNT
    );

    modport slave (
        input  i_START, i_N_receive, i_ABORT, i_MISO,
        output o_DATA, o_BYTE, o_BYTE_VALID, o_DONE, o_BUSY, o_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/nbit_miso_spi_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nbit_miso_spi_buffer
// Brief    : Captures up to N serial MISO bytes into a packed buffer.
//            Define MISO_LSB_FIRST_EN to assemble each byte LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module nbit_miso_spi_buffer #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  wire logic              i_SCK,
    input  wire logic              i_RST,
    nbit_miso_spi_buffer_if.slave  bus
);
    localparam int         c_BIT_W      = $clog2(WIDTH + 1);
    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_RECEIVE = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH*N-1:0] r_data;
    logic [WIDTH-1:0]   r_byte;
    logic [WIDTH-1:0]   r_shift;
    logic [c_BIT_W-1:0] r_bit;
    logic [4:0]         r_count;
    logic [4:0]         r_target;
    logic               r_valid;
    logic               r_done;

    logic [0:0]         w_state_nxt;
    logic [WIDTH*N-1:0] w_data_nxt;
    logic [WIDTH-1:0]   w_byte_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [4:0]         w_count_nxt;
    logic [4:0]         w_target_nxt;
    logic               w_valid_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_assembled;

`ifdef MISO_LSB_FIRST_EN
    assign w_assembled = (r_shift >> 1) | (WIDTH'(bus.i_MISO) << (WIDTH - 1));
`else
    assign w_assembled = (r_shift << 1) | WIDTH'(bus.i_MISO);
`endif

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            r_state  <= c_ST_IDLE;
            r_data   <= '0;
            r_byte   <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_count  <= '0;
            r_target <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_byte   <= w_byte_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_byte_nxt   = r_byte;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.i_START && (bus.i_N_receive != 5'd0)) begin
                    w_state_nxt  = c_ST_RECEIVE;
                    w_data_nxt   = '0;
                    w_count_nxt  = '0;
                    w_bit_nxt    = '0;
                    w_shift_nxt  = '0;
                    w_target_nxt = (bus.i_N_receive > 5'(N)) ? 5'(N) : bus.i_N_receive;
                end
            end
            c_ST_RECEIVE: begin
                // Abort wins even over a byte-completing edge.
                if (bus.i_ABORT) begin
                    w_state_nxt = c_ST_IDLE;
                    w_bit_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (r_bit == c_BIT_W'(WIDTH - 1)) begin
                    for (int k = 0; k < N; k++) begin
                        if (r_count == 5'(k)) begin
                            w_data_nxt[k*WIDTH +: WIDTH] = w_assembled;
                        end
                    end
                    w_byte_nxt  = w_assembled;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = r_count + 5'd1;
                    w_bit_nxt   = '0;
                    w_shift_nxt = '0;
                    if ((r_count + 5'd1) == r_target) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_shift_nxt = w_assembled;
                    w_bit_nxt   = r_bit + c_BIT_W'(1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign bus.o_DATA       = r_data;
    assign bus.o_BYTE       = r_byte;
    assign bus.o_BYTE_VALID = r_valid;
    assign bus.o_DONE       = r_done;
    assign bus.o_BUSY       = (r_state == c_ST_RECEIVE);
    assign bus.o_COUNT      = r_count;
endmodule
`default_nettype wire
